// File: rtl/glb_dma_queue_sched_pkg.sv
// Shared types for the GLB tile DMA queue sequencer.
// Holds the parameter defaults, the queue mode encoding and the FSM state encoding.
package glb_dma_queue_sched_pkg;

    localparam int DMA_Q_DEPTH_DEFAULT     = 4;
    localparam int DMA_Q_GAP_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        DMA_Q_OFF    = 2'd0,
        DMA_Q_SINGLE = 2'd1,
        DMA_Q_REPEAT = 2'd2,
        DMA_Q_STEP   = 2'd3
    } dma_q_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } dma_q_state_e;

endpackage

// File: rtl/glb_dma_queue_sched.sv
// Sequencer for one GLB tile DMA engine (load or store).
// Walks the header slots in order, launches one transfer per valid header,
// waits for done, inserts a programmable gap, invalidates consumed headers
// and raises the tile interrupt at end of pass.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   clk_en              tile clock enable; state frozen while low
//   soft_reset          synchronous soft reset, highest priority
//   cfg_mode            0 OFF, 1 SINGLE, 2 REPEAT, 3 STEP
//   cfg_gap             idle cycles between done and next launch
//   hdr_valid           per-slot header valid bits
//   start_pulse         start trigger
//   dma_done_pulse      active transfer finished
//   dma_launch_pulse    one-cycle launch of slot dma_entry_sel
//   dma_entry_sel       slot index driving the engine (held between launches)
//   dma_busy            high whenever the FSM is not IDLE
//   invalidate_pulse    one-hot clear of the consumed slot
//   interrupt_pulse     one-cycle completion interrupt
//
// state  | meaning
// IDLE   | waiting for a start trigger
// LAUNCH | first launch of a pass is issued
// BUSY   | transfer in flight, waiting for done
// GAP    | counting idle cycles before the next launch
module glb_dma_queue_sched
    import glb_dma_queue_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH = DMA_Q_DEPTH_DEFAULT,
    parameter int GAP_WIDTH   = DMA_Q_GAP_WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clk_en,
    input  logic                           soft_reset,
    input  logic [1:0]                     cfg_mode,
    input  logic [GAP_WIDTH-1:0]           cfg_gap,
    input  logic [QUEUE_DEPTH-1:0]         hdr_valid,
    input  logic                           start_pulse,
    input  logic                           dma_done_pulse,
    output logic                           dma_launch_pulse,
    output logic [$clog2(QUEUE_DEPTH)-1:0] dma_entry_sel,
    output logic                           dma_busy,
    output logic [QUEUE_DEPTH-1:0]         invalidate_pulse,
    output logic                           interrupt_pulse
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    typedef logic [IDX_W-1:0] idx_t;

    dma_q_state_e           state_q, state_d;
    dma_q_mode_e            mode_q, mode_d;
    idx_t                   idx_q, idx_d;
    idx_t                   step_ptr_q, step_ptr_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   launch_q, launch_d;
    idx_t                   sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic [QUEUE_DEPTH-1:0] inval_q, inval_d;
    logic                   irq_q, irq_d;

    dma_q_mode_e cfg_mode_e;
    idx_t        nxt_idx;
    idx_t        start_idx;
    logic        end_of_pass;
    logic        schedule;

    assign cfg_mode_e = dma_q_mode_e'(cfg_mode);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        step_ptr_d  = step_ptr_q;
        gap_cnt_d   = gap_cnt_q;
        launch_d    = 1'b0;
        sel_d       = sel_q;
        inval_d     = '0;
        irq_d       = 1'b0;
        schedule    = 1'b0;
        start_idx   = '0;
        // Power-of-two depth: the natural index wrap is the modulo.
        nxt_idx     = idx_q + idx_t'(1);
        // hdr_valid is the live value at done; our own invalidate is not yet applied.
        end_of_pass = (nxt_idx == '0) || !hdr_valid[nxt_idx] || (cfg_mode_e == DMA_Q_OFF);

        case (state_q)
            IDLE: begin
                if (start_pulse && cfg_mode_e != DMA_Q_OFF) begin
                    mode_d    = cfg_mode_e;
                    start_idx = (cfg_mode_e == DMA_Q_STEP) ? step_ptr_q : '0;
                    idx_d     = start_idx;
                    // An empty first slot drops the start without any output.
                    if (hdr_valid[start_idx]) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                launch_d = 1'b1;
                sel_d    = idx_q;
                state_d  = BUSY;
            end
            BUSY: begin
                if (dma_done_pulse) begin
                    case (mode_q)
                        DMA_Q_SINGLE: begin
                            inval_d = QUEUE_DEPTH'(1) << idx_q;
                            if (end_of_pass) begin
                                irq_d   = 1'b1;
                                state_d = IDLE;
                            end else begin
                                idx_d    = nxt_idx;
                                schedule = 1'b1;
                            end
                        end
                        DMA_Q_REPEAT: begin
                            if (end_of_pass) begin
                                irq_d = 1'b1;
                                idx_d = '0;
                                if (cfg_mode_e == DMA_Q_OFF || !hdr_valid[0]) begin
                                    state_d = IDLE;
                                end else begin
                                    schedule = 1'b1;
                                end
                            end else begin
                                idx_d    = nxt_idx;
                                schedule = 1'b1;
                            end
                        end
                        DMA_Q_STEP: begin
                            inval_d    = QUEUE_DEPTH'(1) << idx_q;
                            irq_d      = 1'b1;
                            step_ptr_d = nxt_idx;
                            state_d    = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    launch_d = 1'b1;
                    sel_d    = idx_q;
                    state_d  = BUSY;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A zero gap launches straight from the done cycle; otherwise the
        // counter is loaded one short so the launch lands g cycles later.
        if (schedule) begin
            if (cfg_gap == '0) begin
                launch_d = 1'b1;
                sel_d    = idx_d;
                state_d  = BUSY;
            end else begin
                gap_cnt_d = cfg_gap - GAP_WIDTH'(1);
                state_d   = GAP;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || soft_reset) begin
            state_q    <= IDLE;
            mode_q     <= DMA_Q_OFF;
            idx_q      <= '0;
            step_ptr_q <= '0;
            gap_cnt_q  <= '0;
            launch_q   <= 1'b0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            inval_q    <= '0;
            irq_q      <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            step_ptr_q <= step_ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            launch_q   <= launch_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            inval_q    <= inval_d;
            irq_q      <= irq_d;
        end else begin
            launch_q   <= 1'b0;
            inval_q    <= '0;
            irq_q      <= 1'b0;
        end
    end

    assign dma_launch_pulse = launch_q;
    assign dma_entry_sel    = sel_q;
    assign dma_busy         = busy_q;
    assign invalidate_pulse = inval_q;
    assign interrupt_pulse  = irq_q;

endmodule

// File: tb/tb_glb_dma_queue_sched.sv
module tb_glb_dma_queue_sched;

    localparam int QD = 4;
    localparam int GW = 8;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en;
    logic          soft_reset;
    logic [1:0]    cfg_mode;
    logic [GW-1:0] cfg_gap;
    logic [QD-1:0] hdr_valid;
    logic          start_pulse;
    logic          dma_done_pulse;
    logic          dma_launch_pulse;
    logic [1:0]    dma_entry_sel;
    logic          dma_busy;
    logic [QD-1:0] invalidate_pulse;
    logic          interrupt_pulse;

    int total  = 0;
    int passed = 0;

    logic       st_v [N];
    logic       dn_v [N];
    logic       en_v [N];
    logic       sr_v [N];
    logic [1:0] md_v [N];

    logic          lo_launch [N];
    logic [1:0]    lo_sel    [N];
    logic          lo_busy   [N];
    logic [QD-1:0] lo_inval  [N];
    logic          lo_irq    [N];

    glb_dma_queue_sched #(.QUEUE_DEPTH(QD), .GAP_WIDTH(GW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clk_en           (clk_en),
        .soft_reset       (soft_reset),
        .cfg_mode         (cfg_mode),
        .cfg_gap          (cfg_gap),
        .hdr_valid        (hdr_valid),
        .start_pulse      (start_pulse),
        .dma_done_pulse   (dma_done_pulse),
        .dma_launch_pulse (dma_launch_pulse),
        .dma_entry_sel    (dma_entry_sel),
        .dma_busy         (dma_busy),
        .invalidate_pulse (invalidate_pulse),
        .interrupt_pulse  (interrupt_pulse)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        clk_en         = 1'b1;
        soft_reset     = 1'b0;
        start_pulse    = 1'b0;
        dma_done_pulse = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        cfg_mode  = 2'd0;
        cfg_gap   = '0;
        hdr_valid = '0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic clear_stim(input logic [1:0] mode);
        for (int i = 0; i < N; i++) begin
            st_v[i] = 1'b0;
            dn_v[i] = 1'b0;
            en_v[i] = 1'b1;
            sr_v[i] = 1'b0;
            md_v[i] = mode;
        end
    endtask

    // Cycle c: inputs driven #1 after an edge, outputs sampled at the same point.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            start_pulse    = st_v[c];
            dma_done_pulse = dn_v[c];
            clk_en         = en_v[c];
            soft_reset     = sr_v[c];
            cfg_mode       = md_v[c];
            lo_launch[c]   = dma_launch_pulse;
            lo_sel[c]      = dma_entry_sel;
            lo_busy[c]     = dma_busy;
            lo_inval[c]    = invalidate_pulse;
            lo_irq[c]      = interrupt_pulse;
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if ({dma_launch_pulse, dma_busy, interrupt_pulse} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {dma_launch_pulse, dma_busy, interrupt_pulse});
        else passed++;
        total++;
        if (dma_entry_sel !== 2'd0) $display("FAIL reset_sel got %0d want 0", dma_entry_sel);
        else passed++;
        total++;
        if (invalidate_pulse !== 4'b0000) $display("FAIL reset_inval got %b want 0000", invalidate_pulse);
        else passed++;
    endtask

    task automatic test_single();
        int nl;
        reset_dut();
        hdr_valid = 4'b0011;
        cfg_gap   = 8'd0;
        clear_stim(2'd1);
        st_v[0] = 1'b1;
        dn_v[7] = 1'b1;
        dn_v[13] = 1'b1;
        run(20);
        nl = 0;
        for (int c = 0; c < 20; c++) nl += int'(lo_launch[c]);
        total++;
        if (nl != 2) $display("FAIL single_launch_count got %0d want 2", nl);
        else passed++;
        total++;
        if (lo_launch[2] !== 1'b1 || lo_sel[2] !== 2'd0) $display("FAIL single_launch0 got %b/%0d want 1/0", lo_launch[2], lo_sel[2]);
        else passed++;
        total++;
        if (lo_busy[1] !== 1'b1 || lo_busy[0] !== 1'b0) $display("FAIL single_busy_start got %b%b want 01", lo_busy[0], lo_busy[1]);
        else passed++;
        total++;
        if (lo_launch[8] !== 1'b1 || lo_sel[8] !== 2'd1 || lo_inval[8] !== 4'b0001) $display("FAIL single_launch1 got %b/%0d/%b want 1/1/0001", lo_launch[8], lo_sel[8], lo_inval[8]);
        else passed++;
        total++;
        if (lo_irq[14] !== 1'b1 || lo_inval[14] !== 4'b0010 || lo_busy[14] !== 1'b0) $display("FAIL single_end got %b/%b/%b want 1/0010/0", lo_irq[14], lo_inval[14], lo_busy[14]);
        else passed++;
        total++;
        if (lo_busy[13] !== 1'b1 || lo_irq[8] !== 1'b0) $display("FAIL single_mid got busy %b irq %b want 1/0", lo_busy[13], lo_irq[8]);
        else passed++;
    endtask

    task automatic test_repeat();
        int nl, ni;
        logic [QD-1:0] inv_or;
        int lc[5];
        reset_dut();
        hdr_valid = 4'b1111;
        cfg_gap   = 8'd3;
        clear_stim(2'd2);
        st_v[0] = 1'b1;
        lc = '{2, 11, 20, 29, 38};
        for (int k = 0; k < 5; k++) dn_v[lc[k] + 5] = 1'b1;
        for (int c = 36; c < N; c++) md_v[c] = 2'd0;
        run(50);
        nl = 0; ni = 0; inv_or = '0;
        for (int c = 0; c < 50; c++) begin
            nl += int'(lo_launch[c]);
            ni += int'(lo_irq[c]);
            inv_or |= lo_inval[c];
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (lo_launch[lc[k]] !== 1'b1 || lo_sel[lc[k]] !== 2'(k % 4)) $display("FAIL repeat_launch%0d got %b/%0d want 1/%0d", k, lo_launch[lc[k]], lo_sel[lc[k]], k % 4);
            else passed++;
        end
        total++;
        if (nl != 5) $display("FAIL repeat_launch_count got %0d want 5", nl);
        else passed++;
        total++;
        if (lo_irq[35] !== 1'b1 || lo_irq[44] !== 1'b1 || ni != 2) $display("FAIL repeat_irq got %b/%b cnt %0d want 1/1 cnt 2", lo_irq[35], lo_irq[44], ni);
        else passed++;
        total++;
        if (inv_or !== 4'b0000) $display("FAIL repeat_no_inval got %b want 0000", inv_or);
        else passed++;
        total++;
        if (lo_busy[43] !== 1'b1 || lo_busy[44] !== 1'b0) $display("FAIL repeat_stop got %b%b want 10", lo_busy[43], lo_busy[44]);
        else passed++;
    endtask

    task automatic test_step();
        reset_dut();
        hdr_valid = 4'b1111;
        cfg_gap   = 8'd0;
        clear_stim(2'd3);
        for (int k = 0; k < 5; k++) begin
            st_v[10 * k]     = 1'b1;
            dn_v[10 * k + 7] = 1'b1;
        end
        run(50);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (lo_launch[10 * k + 2] !== 1'b1 || lo_sel[10 * k + 2] !== 2'(k % 4)) $display("FAIL step_launch%0d got %b/%0d want 1/%0d", k, lo_launch[10 * k + 2], lo_sel[10 * k + 2], k % 4);
            else passed++;
            total++;
            if (lo_irq[10 * k + 8] !== 1'b1 || lo_inval[10 * k + 8] !== 4'(1 << (k % 4)) || lo_busy[10 * k + 8] !== 1'b0) $display("FAIL step_done%0d got %b/%b/%b want 1/%b/0", k, lo_irq[10 * k + 8], lo_inval[10 * k + 8], lo_busy[10 * k + 8], 4'(1 << (k % 4)));
            else passed++;
        end
    endtask

    task automatic test_ignore();
        int nl, ni;
        logic any;
        reset_dut();
        hdr_valid = 4'b1110;
        clear_stim(2'd1);
        st_v[0] = 1'b1;
        dn_v[3] = 1'b1;
        run(10);
        any = 1'b0;
        for (int c = 0; c < 10; c++) any |= lo_launch[c] | lo_busy[c] | lo_irq[c] | (|lo_inval[c]);
        total++;
        if (any !== 1'b0) $display("FAIL ignore_empty_slot got activity %b want 0", any);
        else passed++;

        hdr_valid = 4'b0001;
        cfg_gap   = 8'd0;
        clear_stim(2'd1);
        st_v[0] = 1'b1;
        st_v[4] = 1'b1;
        dn_v[7] = 1'b1;
        run(20);
        nl = 0; ni = 0;
        for (int c = 0; c < 20; c++) begin
            nl += int'(lo_launch[c]);
            ni += int'(lo_irq[c]);
        end
        total++;
        if (nl != 1 || lo_launch[2] !== 1'b1) $display("FAIL ignore_start_busy got count %0d want 1", nl);
        else passed++;
        total++;
        if (ni != 1 || lo_irq[8] !== 1'b1 || lo_inval[8] !== 4'b0001 || lo_busy[8] !== 1'b0) $display("FAIL ignore_single_end got irq %0d inval %b busy %b want 1/0001/0", ni, lo_inval[8], lo_busy[8]);
        else passed++;
    endtask

    task automatic test_soft_reset();
        int nl, ni, nv;
        reset_dut();
        hdr_valid = 4'b0011;
        cfg_gap   = 8'd0;
        clear_stim(2'd1);
        st_v[0]  = 1'b1;
        dn_v[7]  = 1'b1;
        sr_v[10] = 1'b1;
        dn_v[13] = 1'b1;
        st_v[16] = 1'b1;
        run(24);
        nl = 0; ni = 0; nv = 0;
        for (int c = 0; c < 24; c++) begin
            nl += int'(lo_launch[c]);
            ni += int'(lo_irq[c]);
            nv += int'(|lo_inval[c]);
        end
        total++;
        if (lo_busy[10] !== 1'b1 || lo_busy[11] !== 1'b0) $display("FAIL soft_reset_busy got %b%b want 10", lo_busy[10], lo_busy[11]);
        else passed++;
        total++;
        if (ni != 0 || nv != 1) $display("FAIL soft_reset_pulses got irq %0d inval %0d want 0/1", ni, nv);
        else passed++;
        total++;
        if (nl != 3 || lo_launch[18] !== 1'b1 || lo_sel[18] !== 2'd0) $display("FAIL soft_reset_relaunch got count %0d sel %0d want 3/0", nl, lo_sel[18]);
        else passed++;
    endtask

    task automatic test_clk_en();
        logic any;
        reset_dut();
        hdr_valid = 4'b0011;
        cfg_gap   = 8'd2;
        clear_stim(2'd1);
        st_v[0] = 1'b1;
        dn_v[7] = 1'b1;
        for (int c = 9; c < 14; c++) en_v[c] = 1'b0;
        dn_v[20] = 1'b1;
        run(26);
        any = 1'b0;
        for (int c = 9; c < 15; c++) any |= lo_launch[c] | lo_irq[c] | (|lo_inval[c]);
        total++;
        if (any !== 1'b0) $display("FAIL clk_en_quiet got %b want 0", any);
        else passed++;
        total++;
        if (lo_inval[8] !== 4'b0001) $display("FAIL clk_en_inval got %b want 0001", lo_inval[8]);
        else passed++;
        total++;
        if (lo_launch[15] !== 1'b1 || lo_sel[15] !== 2'd1) $display("FAIL clk_en_launch got %b/%0d want 1/1", lo_launch[15], lo_sel[15]);
        else passed++;
        total++;
        if (lo_irq[21] !== 1'b1 || lo_inval[21] !== 4'b0010) $display("FAIL clk_en_end got %b/%b want 1/0010", lo_irq[21], lo_inval[21]);
        else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        cfg_mode  = 2'd0;
        cfg_gap   = '0;
        hdr_valid = '0;
        test_reset();
        test_single();
        test_repeat();
        test_step();
        test_ignore();
        test_soft_reset();
        test_clk_en();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
